// File: rtl/blink_pkg.sv
// Shared types for the blink divider: per-channel operating modes.
package blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_TOGGLE  = 2'd1,
        MODE_PULSE   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_t;

endpackage

// File: rtl/blink_chan.sv
// One divider channel: programmable half-period counter driving led/tick/done flops.
// Outputs registered, first tick H cycles after a write; no backpressure.
module blink_chan
    import blink_pkg::*;
#(
    parameter int CPT_W        = 26,
    parameter int DEFAULT_HALF = 25_000_000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wr,
    input  logic             sync,
    input  logic [CPT_W-1:0] cfg_half,
    input  logic [1:0]       cfg_mode,
    output logic             led,
    output logic             tick,
    output logic             done
);

    localparam logic [CPT_W-1:0] DEF_HALF = CPT_W'(DEFAULT_HALF);

    mode_t            mode_q, mode_d;
    logic [CPT_W-1:0] half_q, half_d;
    logic [CPT_W-1:0] cnt_q, cnt_d;
    logic             led_d, tick_d, done_d;
    logic             fired;
    logic             active;
    logic             wrap;

    assign fired  = (mode_q == MODE_ONESHOT) && done;
    assign active = (mode_q != MODE_OFF) && (half_q != '0) && !fired;
    assign wrap   = (cnt_q == half_q - CPT_W'(1));

    always_comb begin
        mode_d = mode_q;
        half_d = half_q;
        cnt_d  = '0;
        led_d  = 1'b0;
        tick_d = 1'b0;
        done_d = 1'b0;
        if (wr) begin
            mode_d = mode_t'(cfg_mode);
            half_d = cfg_half;
        end
        // A write or sync clears the channel even on its wrap cycle.
        if (!(wr || sync)) begin
            if (active) begin
                if (wrap) begin
                    tick_d = 1'b1;
                    case (mode_q)
                        MODE_TOGGLE:  led_d = ~led;
                        MODE_PULSE:   led_d = 1'b1;
                        MODE_ONESHOT: begin
                            led_d  = 1'b1;
                            done_d = 1'b1;
                        end
                        default:      led_d = 1'b0;
                    endcase
                end else begin
                    cnt_d = cnt_q + CPT_W'(1);
                    led_d = (mode_q == MODE_PULSE) ? 1'b0 : led;
                end
            end else if (fired) begin
                led_d  = led;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q <= MODE_TOGGLE;
            half_q <= DEF_HALF;
            cnt_q  <= '0;
            led    <= 1'b0;
            tick   <= 1'b0;
            done   <= 1'b0;
        end else begin
            mode_q <= mode_d;
            half_q <= half_d;
            cnt_q  <= cnt_d;
            led    <= led_d;
            tick   <= tick_d;
            done   <= done_d;
        end
    end

endmodule

// File: rtl/blink_divider.sv
// Multi-channel LED blinker: decodes config writes and fans sync out to NB_CH channels.
// Outputs come straight from channel flops; writes always accepted, out-of-range ones dropped.
module blink_divider #(
    parameter int NB_CH        = 4,
    parameter int CPT_W        = 26,
    parameter int DEFAULT_HALF = 25_000_000,
    localparam int CH_W        = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CPT_W-1:0] cfg_half,
    input  logic [1:0]       cfg_mode,
    input  logic             sync,
    output logic [NB_CH-1:0] led,
    output logic [NB_CH-1:0] tick,
    output logic [NB_CH-1:0] done
);

    logic [NB_CH-1:0] ch_we;

    for (genvar i = 0; i < NB_CH; i++) begin : g_ch
        assign ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));

        blink_chan #(
            .CPT_W        (CPT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_chan (
            .CLK      (CLK),
            .RST      (RST),
            .wr       (ch_we[i]),
            .sync     (sync),
            .cfg_half (cfg_half),
            .cfg_mode (cfg_mode),
            .led      (led[i]),
            .tick     (tick[i]),
            .done     (done[i])
        );
    end

endmodule
